// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
package seg_scan_mux_pkg;

  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_BLINK_TICKS = 50;
  localparam int PWM_W           = 4;

  // Wide enough for any legal SEG_W / NUM_DIGITS; users slice the low bits.
  localparam logic [31:0] SEG_BLANK = '1;
  localparam logic [15:0] ANODE_OFF = '1;

endpackage

// File: rtl/seg_scan_mux_if.sv
// Host-side bundle of the scanner: frame load inputs and the display drive outputs.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8
);
  import seg_scan_mux_pkg::*;

  logic [NUM_DIGITS*SEG_W-1:0] digits;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic                        load;
  logic [PWM_W-1:0]            brightness;
  logic [SEG_W-1:0]            seg_out;
  logic [NUM_DIGITS-1:0]       anodes;
  logic                        frame_start;

  modport master (
    output digits, digit_en, blink_mask, load, brightness,
    input  seg_out, anodes, frame_start
  );

  modport slave (
    input  digits, digit_en, blink_mask, load, brightness,
    output seg_out, anodes, frame_start
  );

endinterface

// File: rtl/seg_scan_mux_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 and flags the last count of each slot.
module tick_gen
  import seg_scan_mux_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (cnt == CW'(DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed display driver with shadowed frame load, per-digit blink and PWM dimming.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SEG_W       = 8,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input logic           clk,
  input logic           rst,
  seg_scan_mux_if.slave bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef struct packed {
    logic [NUM_DIGITS*SEG_W-1:0] dig;
    logic [NUM_DIGITS-1:0]       en;
    logic [NUM_DIGITS-1:0]       blink;
  } frame_buf_t;

  logic             tick;
  logic [IW-1:0]    idx;
  logic [PWM_W-1:0] pwm_cnt;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic             slot_first;
  logic             frame_wrap;
  logic             pending;
  frame_buf_t       pend_buf;
  frame_buf_t       act_buf;
  frame_buf_t       load_val;

  logic             visible;
  logic             pwm_on;
  logic [SEG_W-1:0] seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_wrap = tick && (idx == IW'(NUM_DIGITS - 1));
  assign load_val   = '{dig: bus.digits, en: bus.digit_en, blink: bus.blink_mask};

  // slot_first marks the first cycle of a slot; reset leaves the prescaler at 0, hence 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx         <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      slot_first  <= 1'b1;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      slot_first <= tick;
      if (tick) begin
        idx <= frame_wrap ? '0 : idx + 1'b1;
        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the frame buffers are plain flops, so they are reset explicitly to a blank frame.
  // A load coinciding with the wrap lands in pend_buf and waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_buf <= '0;
      act_buf  <= '0;
      pending  <= 1'b0;
    end else begin
      if (frame_wrap && pending)
        act_buf <= pend_buf;
      if (bus.load) begin
        pend_buf <= load_val;
        pending  <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    seg_d   = SEG_BLANK[SEG_W-1:0];
    an_d    = ANODE_OFF[NUM_DIGITS-1:0];
    pwm_on  = (pwm_cnt <= bus.brightness);
    visible = act_buf.en[idx] && !(act_buf.blink[idx] && blink_phase);
    if (visible) begin
      seg_d = act_buf.dig[int'(idx)*SEG_W +: SEG_W];
      if (pwm_on)
        an_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.seg_out     <= SEG_BLANK[SEG_W-1:0];
      bus.anodes      <= ANODE_OFF[NUM_DIGITS-1:0];
      bus.frame_start <= 1'b0;
    end else begin
      bus.seg_out     <= seg_d;
      bus.anodes      <= an_d;
      bus.frame_start <= slot_first && (idx == '0);
    end
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter SEG_W, default 8, segment pattern width per digit (7 segments + dp).
REQ-003 SHALL have parameter TICK_DIV, default 50000, clk cycles per digit slot (>=2).
REQ-004 SHALL have parameter BLINK_TICKS, default 50, slot ticks per blink half-period (>=1).
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port digits  in  NUM_DIGITS*SEG_W  segment patterns; digit i at bits [i*SEG_W +: SEG_W], active-low.
REQ-008 SHALL have port digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-009 SHALL have port blink_mask  in  NUM_DIGITS  per-digit blink select.
REQ-010 SHALL have port load  in  1  single-cycle strobe capturing digits/digit_en/blink_mask.
REQ-011 SHALL have port brightness  in  4  PWM duty level 0..15.
REQ-012 SHALL have port seg_out  out  SEG_W  segment drive of the active digit, active-low, registered.
REQ-013 SHALL have port anodes  out  NUM_DIGITS  digit select, one-hot-low or all-ones, registered.
REQ-014 SHALL have port frame_start  out  1  one-cycle pulse marking the start of slot 0.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high in the cycle prescaler = TICK_DIV-1.
REQ-016 Digit index idx SHALL advance on each tick edge, wrapping from NUM_DIGITS-1 to 0.
REQ-017 load SHALL capture inputs into a pending buffer and set a pending flag; a later load before apply overwrites it (last wins).
REQ-018 The pending buffer SHALL be copied to active registers, and pending cleared, on the edge where idx wraps to 0; a load in that same cycle is held for the following frame.
REQ-019 A free-running 4-bit pwm_cnt SHALL increment every cycle; pwm_on = (pwm_cnt <= brightness).
REQ-020 Blink: a tick counter SHALL toggle blink_phase every BLINK_TICKS ticks; blink_phase starts at 0.
REQ-021 Digit idx is visible when active_en[idx]=1 and not (active_blink[idx]=1 and blink_phase=1).
REQ-022 Each cycle seg_out SHALL register active pattern[idx] when visible, else all ones.
REQ-023 Each cycle anodes SHALL register all ones with bit idx cleared when visible and pwm_on, else all ones.
REQ-024 Outputs SHALL have one-cycle latency from idx, pwm_cnt and active registers.
REQ-025 frame_start SHALL be high for exactly the one cycle in which registered outputs first reflect idx = 0.
REQ-026 brightness changes SHALL take effect in the next cycle without glitching slot timing.

Reset
REQ-027 With rst=0 at a clock edge: prescaler, idx, pwm_cnt, blink counter, blink_phase, pending = 0; pending and active buffers cleared (en = 0).
REQ-028 Reset values: seg_out all ones, anodes all ones, frame_start 0.
REQ-029 Reset asserted mid-frame SHALL reach the reset state in one edge; after release the first frame_start follows within one cycle-latency of slot 0.

Structure
REQ-030 Shared package/header SHALL hold SEG_BLANK (all ones), ANODE_OFF, and default TICK_DIV/BLINK_TICKS constants.
REQ-031 Prescaler SHALL be one sub-module, tick_gen (parameter DIV; ports clk, rst, tick).
REQ-032 No other sub-modules; no latches; single clock domain.

Verification (NUM_DIGITS=4, TICK_DIV=4, BLINK_TICKS=4 unless noted)
REQ-033 Reset: rst=0 for 3 cycles mid-scan -> seg_out=8'hFF, anodes=4'b1111, frame_start=0.
REQ-034 Scan: load C0,F9,A4,B0, en=1111, brightness=15 -> anodes 1110,1101,1011,0111 each 4 cycles with matching seg_out; frame_start once per 16 cycles.
REQ-035 Enable: en=0101 -> slots 1 and 3 show anodes=1111, seg_out=FF; slot timing unchanged.
REQ-036 PWM (TICK_DIV=16): brightness=3 -> active anode low 4 of 16 cycles per slot; brightness=0 -> low 1 of 16.
REQ-037 Shadow load: load at slot 2, then second load at slot 3 -> second pattern appears only from next slot 0; no mixed frame.
REQ-038 Blink: blink_mask=0001 -> digit 0 shown in frame 0, blanked (anodes=1111, seg_out=FF) in frame 1, shown in frame 2.
